// File: rtl/shift_restore_seq.sv
// Iterative inverse of a forward shifter: rebuilds the original operand from the
// shifted word and the bits it shifted out, one bit position per cycle.
module shift_restore_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shifted,
  input  logic [WIDTH-1:0] overflow,
  input  logic [WIDTH-1:0] shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] restored,
  output logic             err,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for start, in_ready=1
  // SHIFT | one restore step per cycle, cnt_q = steps remaining
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam int AW = (WIDTH > 2) ? WIDTH - 2 : 1;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [AW:0] WIDTH_C = (AW + 1)'(WIDTH);

  if (WIDTH < 2) begin : g_bad_width
    $error("shift_restore_seq: WIDTH must be at least 2");
  end

  logic [AW-1:0] amt;
  if (WIDTH > 2) begin : g_amt
    assign amt = shift[WIDTH-2:1];
  end else begin : g_amt_none
    assign amt = '0;
  end

  // The fill bit only matters to the forward shifter.
  logic unused_fill;
  assign unused_fill = shift[WIDTH-1];

  state_t          state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dir_d = shift[0];
          ovf_d = overflow;
          err_d = 1'b0;
          cnt_d = '0;
          if ({1'b0, amt} >= WIDTH_C) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (amt == '0) begin
            data_d  = shifted;
            state_d = S_DONE;
          end else begin
            data_d  = shifted;
            cnt_d   = CW'(amt);
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // Left restore consumes overflow LSB-first; right restore MSB-first (bit cnt-1).
        if (dir_q) begin
          data_d = {data_q[WIDTH-2:0], ovf_q[cnt_q - CW'(1)]};
        end else begin
          data_d = {ovf_q[0], data_q[WIDTH-1:1]};
          ovf_d  = ovf_q >> 1;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign restored  = data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_shift_restore_seq.sv
// Directed bench for shift_restore_seq: WIDTH=4 instance for the main flows,
// WIDTH=8 instance for the out-of-range and long-shift boundaries.
module tb_shift_restore_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  logic       start4 = 1'b0, out_ready4 = 1'b0;
  logic [3:0] shifted4 = '0, ovf4 = '0, shift4 = '0;
  logic       in_ready4, out_valid4, err4, busy4;
  logic [3:0] restored4;

  logic       start8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] shifted8 = '0, ovf8 = '0, shift8 = '0;
  logic       in_ready8, out_valid8, err8, busy8;
  logic [7:0] restored8;

  always #5 clk = ~clk;

  shift_restore_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_ready(in_ready4),
    .shifted(shifted4), .overflow(ovf4), .shift(shift4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .restored(restored4), .err(err4), .busy(busy4)
  );

  shift_restore_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_ready(in_ready8),
    .shifted(shifted8), .overflow(ovf8), .shift(shift8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .restored(restored8), .err(err8), .busy(busy8)
  );

  task automatic issue4(input logic [3:0] s, input logic [3:0] o, input logic [3:0] sh);
    shifted4 = s; ovf4 = o; shift4 = sh; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic retire4();
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready4); end
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy4); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err4); end
    checks++; if (restored4 !== 4'h0) begin errors++; $display("FAIL reset_restored got %h exp 0", restored4); end
    checks++; if (restored8 !== 8'h00) begin errors++; $display("FAIL reset_restored8 got %h exp 00", restored8); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_left();
    issue4(4'b0110, 4'b0001, 4'h2);
    checks++; if (out_valid4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL left_e0 got valid=%b busy=%b exp 0/1", out_valid4, busy4); end
    @(posedge clk); #1;
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL left_valid got %b exp 1", out_valid4); end
    checks++; if (restored4 !== 4'b1011 || err4 !== 1'b0) begin errors++; $display("FAIL left_result got %b err=%b exp 1011 err=0", restored4, err4); end
    retire4();
    checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin errors++; $display("FAIL left_retire got rdy=%b valid=%b exp 1/0", in_ready4, out_valid4); end
    // amt=3 with a stray overflow bit above the used range
    issue4(4'b0001, 4'b1110, 4'h6);
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL left3_early got %b exp 0", out_valid4); end
    @(posedge clk); #1;
    checks++; if (out_valid4 !== 1'b1 || restored4 !== 4'b1100) begin errors++; $display("FAIL left3_result got v=%b %b exp 1 1100", out_valid4, restored4); end
    retire4();
  endtask

  task automatic test_right();
    logic [3:0] src [2];
    src[0] = 4'b0010; src[1] = 4'b1110;
    for (int i = 0; i < 2; i++) begin
      issue4(src[i], 4'b0011, 4'h5);
      @(posedge clk); #1;
      checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL right_early[%0d] got %b exp 0", i, out_valid4); end
      @(posedge clk); #1;
      checks++; if (out_valid4 !== 1'b1 || restored4 !== 4'b1011) begin errors++; $display("FAIL right_result[%0d] got v=%b %b exp 1 1011", i, out_valid4, restored4); end
      retire4();
    end
  endtask

  task automatic test_zero_amount();
    issue4(4'b1001, 4'b1111, 4'h1);
    checks++; if (out_valid4 !== 1'b1) begin errors++; $display("FAIL zero_valid got %b exp 1", out_valid4); end
    checks++; if (restored4 !== 4'b1001 || err4 !== 1'b0) begin errors++; $display("FAIL zero_result got %b err=%b exp 1001 err=0", restored4, err4); end
    retire4();
  endtask

  task automatic test_backpressure();
    issue4(4'b0110, 4'b0001, 4'h2);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin shifted4 = 4'b0000; shift4 = 4'h1; start4 = 1'b1; end
      else start4 = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid4 !== 1'b1 || restored4 !== 4'b1011) begin errors++; $display("FAIL hold[%0d] got v=%b %b exp 1 1011", c, out_valid4, restored4); end
    end
    // start high on the retiring edge must not be taken
    shifted4 = 4'b0000; shift4 = 4'h1; start4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; out_ready4 = 1'b0;
    checks++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || busy4 !== 1'b0) begin errors++; $display("FAIL bp_retire got rdy=%b v=%b busy=%b exp 1/0/0", in_ready4, out_valid4, busy4); end
  endtask

  task automatic test_reset_mid();
    issue4(4'b0110, 4'b0101, 4'h7);
    @(posedge clk); #1;
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy4); end
    rst = 1'b1; #1;
    checks++; if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++; $display("FAIL mid_rst_ctrl got v=%b busy=%b rdy=%b exp 0/0/1", out_valid4, busy4, in_ready4); end
    checks++; if (restored4 !== 4'h0) begin errors++; $display("FAIL mid_rst_restored got %b exp 0000", restored4); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue4(4'b1000, 4'b0101, 4'h7);
    repeat (2) @(posedge clk); #1;
    checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL after_rst_early got %b exp 0", out_valid4); end
    @(posedge clk); #1;
    checks++; if (out_valid4 !== 1'b1 || restored4 !== 4'b0101 || err4 !== 1'b0) begin errors++; $display("FAIL after_rst_result got v=%b %b err=%b exp 1 0101 0", out_valid4, restored4, err4); end
    retire4();
  endtask

  task automatic test_out_of_range();
    logic [7:0] sh [2];
    int n;
    sh[0] = 8'h12; sh[1] = 8'h10;   // amt=9 and amt=8
    for (int i = 0; i < 2; i++) begin
      shifted8 = 8'hA5; ovf8 = 8'hFF; shift8 = sh[i]; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      checks++; if (out_valid8 !== 1'b1 || err8 !== 1'b1 || restored8 !== 8'h00) begin errors++; $display("FAIL oor[%0d] got v=%b err=%b %h exp 1 1 00", i, out_valid8, err8, restored8); end
      out_ready8 = 1'b1; @(posedge clk); #1; out_ready8 = 1'b0;
    end
    // amt=7 left: largest in-range amount
    shifted8 = 8'h01; ovf8 = 8'h7F; shift8 = 8'h0E; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (out_valid8 !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (n !== 7) begin errors++; $display("FAIL max_amt_latency got %0d exp 7", n); end
    checks++; if (restored8 !== 8'hFE || err8 !== 1'b0) begin errors++; $display("FAIL max_amt_result got %h err=%b exp FE 0", restored8, err8); end
    out_ready8 = 1'b1; @(posedge clk); #1; out_ready8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left();
    test_right();
    test_zero_amount();
    test_backpressure();
    test_reset_mid();
    test_out_of_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_restore_seq.md
SHIFT_RESTORE_SEQ -- requirements
Module: shift_restore_seq

Interface
REQ-001 Parameter: WIDTH, default 4; operand width in bits; WIDTH < 2 SHALL raise an elaboration-time $error.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a restore; accepted only when in_ready=1.
REQ-006 Port: in_ready  output  1  high only in IDLE.
REQ-007 Port: shifted  input  WIDTH  shifted data word (forward shifter "out").
REQ-008 Port: overflow  input  WIDTH  bits shifted out by the forward shift.
REQ-009 Port: shift  input  WIDTH  control word: bit0 = direction (0 left, 1 right), bits[WIDTH-2:1] = amount, bit[WIDTH-1] = fill (ignored).
REQ-010 Port: out_valid  output  1  restored result available.
REQ-011 Port: out_ready  input  1  consumer accepts the result.
REQ-012 Port: restored  output  WIDTH  reconstructed original operand.
REQ-013 Port: err  output  1  amount out of range for the current result.
REQ-014 Port: busy  output  1  high in SHIFT or DONE.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, DONE; reset state IDLE.
REQ-016 The accepting edge E0 is a rising clk edge with start=1 and in_ready=1; shifted, overflow and shift SHALL be captured at E0 and ignored otherwise.
REQ-017 The block SHALL take the amount amt = shift[WIDTH-2:1] as unsigned.
REQ-018 Left-inverse (dir=0): restored SHALL equal (shifted >> amt) | (overflow[amt-1:0] << (WIDTH-amt)).
REQ-019 Right-inverse (dir=1): restored SHALL equal (shifted << amt) | overflow[amt-1:0]; this result applies to both logical and arithmetic forward shifts.
REQ-020 Overflow bits above index amt-1 SHALL be ignored.
REQ-021 Computation SHALL be iterative, one bit position per SHIFT cycle, with no barrel shifter.
REQ-022 Left-inverse step: data <= {ovf bit k, data[WIDTH-1:1]} for k = 0..amt-1.
REQ-023 Right-inverse step: data <= {data[WIDTH-2:0], ovf bit amt-1-k} for k = 0..amt-1.
REQ-024 If 1 <= amt <= WIDTH-1, E0 SHALL enter SHIFT; after exactly amt cycles in SHIFT the FSM SHALL enter DONE, so out_valid rises at edge E0+amt.
REQ-025 If amt = 0, E0 SHALL enter DONE directly with restored = shifted and err = 0.
REQ-026 If amt >= WIDTH, E0 SHALL enter DONE directly with restored = 0 and err = 1.
REQ-027 In DONE, out_valid SHALL be 1 and restored/err SHALL be held stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-028 out_valid and in_ready SHALL never be high together, so no new request is accepted at the edge that retires a result (minimum one IDLE cycle between results).
REQ-029 start while busy=1 SHALL be ignored; that request is not queued.
REQ-030 out_ready outside DONE SHALL have no effect.
REQ-031 The internal step counter SHALL be sized ceil(log2(WIDTH)) bits minimum and SHALL not wrap within a valid operation.

Reset
REQ-032 On rst=1, at any time and in any state, the FSM SHALL go to IDLE immediately (asynchronously).
REQ-033 During reset: in_ready=1, out_valid=0, busy=0, err=0, restored=0, and the counter and data registers SHALL be cleared.
REQ-034 Reset mid-SHIFT or mid-DONE SHALL discard the operation; after rst deasserts, the first accepted request SHALL behave as from power-up.

Verification (WIDTH=4)
REQ-035 Left restore: shifted=4'b0110, overflow=4'b0001, shift=4'h2 (left, amt=1) -> out_valid at E0+1, restored=4'b1011, err=0.
REQ-036 Right restore: shifted=4'b0010, overflow=4'b0011, shift=4'h5 (right, amt=2) -> out_valid at E0+2, restored=4'b1011; repeat with shifted=4'b1110 (arithmetic forward) -> restored=4'b1011.
REQ-037 Zero amount and garbage overflow: shift=4'h1 (amt=0), shifted=4'b1001, overflow=4'b1111 -> out_valid at E0, restored=4'b1001.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles and pulse start during DONE -> restored held stable, pulsed start ignored; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-039 Reset mid-operation: assert rst one cycle into a 3-step SHIFT (shift=4'h7) -> immediately out_valid=0, busy=0, restored=0; next request completes correctly.
REQ-040 Out-of-range amount: WIDTH=8, amt=9 -> out_valid at E0, err=1, restored=0.
